clkdiv_multi: RTL and testbench
===============================

# clkdiv_multi

Parametrised multi-channel clock-enable generator: the fabric-side successor to the single fixed-ratio MMCM output. It produces, per channel, a one-cycle `tick` enable and a registered square wave at clk/div. Each channel's divisor can be changed at runtime through a valid/ready handshake, and the change is applied glitch-free at that channel's wrap boundary. A `locked` flag mirrors MMCM LOCKED semantics for downstream reset sequencing.

## Interface
- CHANNELS, 2: number of independent divider channels (1–8).
- DIV_W, 16: divisor/counter width in bits.
- DEFAULT_DIV, 120: reset divisor for every channel.
- LOCK_CYCLES, 16: clk cycles of stable operation before `locked` asserts (≥1).
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  reconfiguration request.
- cfg_ready  output  1  block can accept a request.
- cfg_chan  input  CH_W = max(1, clog2(CHANNELS))  target channel.
- cfg_div  input  DIV_W  new divisor; 0 is treated as 1.
- cfg_phase  input  DIV_W  initial count on apply. Present only with CLKDIV_PHASE_EN.
- tick  output  CHANNELS  one-cycle pulse per channel period.
- clk_out  output  CHANNELS  registered square wave per channel.
- locked  output  1  all channels are stable at their programmed ratio.

## Operation
- Per channel: `div[i]` register; `cnt[i]` counts 0 → div[i]−1, then wraps to 0.
- Wrap cycle for channel i: the cycle in which cnt[i] == div[i]−1.
- tick[i] is a registered decode of (cnt[i] == div[i]−1).
- clk_out[i] is a registered decode of (cnt[i] < ceil(div[i]/2)).
  - div=1: tick and clk_out are constantly 1 after the first cycle.
  - Odd div: high phase is one cycle longer than low phase.
- Control FSM states: LOCKING, IDLE, PENDING.
  - LOCKING: lock counter runs; locked=0; cfg_ready=0. After LOCK_CYCLES cycles → IDLE.
  - IDLE: locked=1, cfg_ready=1. On cfg_valid & cfg_ready, capture {chan, div, phase} into pending registers.
    - cfg_chan ≥ CHANNELS: request is dropped; stay in IDLE.
    - Otherwise → PENDING; locked drops the following cycle.
  - PENDING: cfg_ready=0, locked=0. At the target channel's next wrap cycle, load div[i] := pending div and cnt[i] := start value, then → LOCKING with the lock counter cleared.
- Start value is 0, or the phase value when CLKDIV_PHASE_EN is defined.
- Non-target channels run undisturbed throughout.
- Simultaneous events: if a request is accepted in the target channel's wrap cycle, it is not applied at that wrap; it is applied at the following wrap.
- Reset mid-operation (reset low at any time): all state returns to reset values immediately, and any pending request is discarded.

## Timing
- Reset values:
  - cnt=0, div=DEFAULT_DIV.
  - tick=0, clk_out=0, locked=0, cfg_ready=0.
  - FSM=LOCKING, lock counter=0.
- First rising edge after reset release: counters start. tick and clk_out lag cnt by 1 cycle.
- locked first rises LOCK_CYCLES+1 edges after reset release. cfg_ready rises in the same cycle.
- Accept → apply: between 1 and old div cycles, depending on the channel's current count.
- Apply → locked: LOCK_CYCLES+1 cycles.
- The first tick at the new ratio appears 1 cycle after the first wrap under the new div.
- The output period changes only at a wrap boundary, so no runt high or low pulse is ever shorter than min(old, new) half-period.
- cfg_ready is registered. A requester must hold cfg_valid and its payload stable until it samples cfg_ready=1 at the edge of acceptance.

## Configuration
- Macro: CLKDIV_PHASE_EN.
- Defined:
  - cfg_phase port exists.
  - On apply, cnt[i] := min(cfg_phase, newdiv−1), so channels can be phase-aligned or staggered.
- Undefined:
  - No cfg_phase port and no phase register.
  - cnt[i] := 0 on apply.
- All other behaviour is identical in both builds.

## Test plan
- Reset release, defaults (CHANNELS=2, DEFAULT_DIV=120, LOCK_CYCLES=16) → locked rises at edge 17; tick[0] and tick[1] pulse every 120 cycles, aligned; clk_out high for 60 and low for 60.
- Reconfigure ch1 to div=10 while ch1 is at cnt=50 → cfg_ready drops next cycle; ch1 switches after 70 more cycles; tick[1] then has period 10; ch0 is unaffected; locked returns 17 cycles after apply.
- cfg_div=0 and cfg_div=1 → tick[i] is constantly 1; clk_out[i] is constantly 1.
- cfg_div=7 → clk_out high 4, low 3; one tick per 7 cycles.
- Request accepted in ch0's wrap cycle → applied one full old period later. cfg_chan=3 with CHANNELS=2 → dropped; locked stays 1; cfg_ready stays 1.
- Reset pulled low while in PENDING → all outputs 0 immediately; after release, div=120 (pending request lost). With CLKDIV_PHASE_EN, applying div=8 with phase=20 → cnt loads 7, so tick appears 1 cycle after apply.

Source files
------------

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: per-channel tick / square-wave generator with runtime divisor changes applied at wrap boundaries.
// Build option CLKDIV_PHASE_EN adds cfg_phase, the start count loaded when a new divisor is applied.
module clkdiv_multi #(
  parameter int CHANNELS    = 2,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 120,
  parameter int LOCK_CYCLES = 16,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [DIV_W-1:0]    cfg_div,
`ifdef CLKDIV_PHASE_EN
  input  logic [DIV_W-1:0]    cfg_phase,
`endif
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] clk_out,
  output logic                locked
);

  localparam int               LCK_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

  typedef enum logic [1:0] {LOCKING, IDLE, PENDING} state_e;

  state_e              state_q, state_d;
  logic [LCK_W-1:0]    lock_cnt_q, lock_cnt_d;
  logic                locked_q, locked_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic [CH_W-1:0]     pend_chan_q, pend_chan_d;
  logic [DIV_W-1:0]    pend_div_q, pend_div_d;
  logic [DIV_W-1:0]    start_val;

  logic [DIV_W-1:0]    cnt_q [CHANNELS];
  logic [DIV_W-1:0]    cnt_d [CHANNELS];
  logic [DIV_W-1:0]    div_q [CHANNELS];
  logic [DIV_W-1:0]    div_d [CHANNELS];
  logic [CHANNELS-1:0] tick_q, tick_d;
  logic [CHANNELS-1:0] clk_out_q, clk_out_d;
  logic [CHANNELS-1:0] wrap, apply;

`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0]    pend_phase_q, pend_phase_d;

  assign start_val = (pend_phase_q < pend_div_q) ? pend_phase_q : pend_div_q - ONE;
`else
  assign start_val = '0;
`endif

  // A pending change only lands on its own channel's wrap, so the period never tears mid-cycle.
  always_comb begin
    wrap  = '0;
    apply = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wrap[i]  = (cnt_q[i] == div_q[i] - ONE);
      apply[i] = (state_q == PENDING) && (pend_chan_q == CH_W'(i)) && wrap[i];
    end
  end

  always_comb begin
    tick_d    = '0;
    clk_out_d = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      cnt_d[i]     = wrap[i] ? '0 : cnt_q[i] + ONE;
      div_d[i]     = div_q[i];
      tick_d[i]    = wrap[i];
      clk_out_d[i] = cnt_q[i] < ((div_q[i] >> 1) + DIV_W'(div_q[i][0]));
      if (apply[i]) begin
        div_d[i] = pend_div_q;
        cnt_d[i] = start_val;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    pend_chan_d = pend_chan_q;
    pend_div_d  = pend_div_q;
`ifdef CLKDIV_PHASE_EN
    pend_phase_d = pend_phase_q;
`endif
    unique case (state_q)
      LOCKING: begin
        if (lock_cnt_q == LCK_W'(LOCK_CYCLES)) state_d = IDLE;
        else                                   lock_cnt_d = lock_cnt_q + LCK_W'(1);
      end
      IDLE: begin
        if (cfg_valid && cfg_ready_q && (int'(cfg_chan) < CHANNELS)) begin
          state_d     = PENDING;
          pend_chan_d = cfg_chan;
          pend_div_d  = (cfg_div == '0) ? ONE : cfg_div;
`ifdef CLKDIV_PHASE_EN
          pend_phase_d = cfg_phase;
`endif
        end
      end
      PENDING: begin
        if (|apply) begin
          state_d    = LOCKING;
          lock_cnt_d = '0;
        end
      end
      default: state_d = LOCKING;
    endcase
    // Outputs are registered from the next state so ready/locked drop right after the accepting edge.
    locked_d    = (state_d == IDLE);
    cfg_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LOCKING;
      lock_cnt_q  <= '0;
      locked_q    <= 1'b0;
      cfg_ready_q <= 1'b0;
      pend_chan_q <= '0;
      pend_div_q  <= ONE;
`ifdef CLKDIV_PHASE_EN
      pend_phase_q <= '0;
`endif
      tick_q      <= '0;
      clk_out_q   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= DIV_RST;
      end
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      locked_q    <= locked_d;
      cfg_ready_q <= cfg_ready_d;
      pend_chan_q <= pend_chan_d;
      pend_div_q  <= pend_div_d;
`ifdef CLKDIV_PHASE_EN
      pend_phase_q <= pend_phase_d;
`endif
      tick_q      <= tick_d;
      clk_out_q   <= clk_out_d;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
    end
  end

  assign tick      = tick_q;
  assign clk_out   = clk_out_q;
  assign locked    = locked_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed plus randomized reconfiguration traffic; an arithmetic reference model
// predicts every output cycle into a queue and a separate monitor compares against the DUT.
module tb_clkdiv_multi;

  localparam int CHANNELS    = 3;
  localparam int DIV_W       = 16;
  localparam int DEFAULT_DIV = 120;
  localparam int LOCK_CYCLES = 16;
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                clk       = 1'b0;
  logic                reset     = 1'b0;
  logic                cfg_valid = 1'b0;
  logic                cfg_ready;
  logic [CH_W-1:0]     cfg_chan  = '0;
  logic [DIV_W-1:0]    cfg_div   = '0;
`ifdef CLKDIV_PHASE_EN
  logic [DIV_W-1:0]    cfg_phase = '0;
`endif
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] clk_out;
  logic                locked;

  clkdiv_multi #(
    .CHANNELS(CHANNELS),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan),
    .cfg_div(cfg_div),
`ifdef CLKDIV_PHASE_EN
    .cfg_phase(cfg_phase),
`endif
    .tick(tick),
    .clk_out(clk_out),
    .locked(locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] clk_out;
    logic                locked;
    logic                ready;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: each channel is an epoch (edge of last apply), a start count and a divisor;
  // the count seen after edge t is (start + t - epoch) mod div.
  int unsigned m_t;
  int unsigned m_ep [CHANNELS];
  int unsigned m_st [CHANNELS];
  int unsigned m_dv [CHANNELS];
  bit          m_pend;
  bit          m_ready;
  int unsigned m_lock_at;
  int unsigned p_chan, p_div, p_phase;

  function automatic int unsigned cnt_at(input int unsigned ch, input int unsigned t);
    return (m_st[ch] + (t - m_ep[ch])) % m_dv[ch];
  endfunction

  function automatic void model_reset();
    m_t       = 0;
    m_pend    = 1'b0;
    m_ready   = 1'b0;
    m_lock_at = LOCK_CYCLES + 1;
    for (int i = 0; i < CHANNELS; i++) begin
      m_ep[i] = 0;
      m_st[i] = 0;
      m_dv[i] = DEFAULT_DIV;
    end
  endfunction

  initial begin : model
    exp_t        e;
    int unsigned c;
    model_reset();
    forever begin
      @(posedge clk);
      if (!reset) begin
        model_reset();
        exp_q.push_back('0);
      end else begin
        m_t++;
        e = '0;
        for (int i = 0; i < CHANNELS; i++) begin
          c            = cnt_at(i, m_t - 1);
          e.tick[i]    = (c == m_dv[i] - 1);
          e.clk_out[i] = (c < (m_dv[i] + 1) / 2);
        end
        if (m_pend) begin
          if (cnt_at(p_chan, m_t - 1) == m_dv[p_chan] - 1) begin
            m_dv[p_chan] = p_div;
`ifdef CLKDIV_PHASE_EN
            m_st[p_chan] = (p_phase < p_div) ? p_phase : p_div - 1;
`else
            m_st[p_chan] = 0;
`endif
            m_ep[p_chan] = m_t;
            m_pend       = 1'b0;
            m_lock_at    = m_t + LOCK_CYCLES + 1;
          end
        end else if (m_ready && cfg_valid && (int'(cfg_chan) < CHANNELS)) begin
          m_pend = 1'b1;
          p_chan = cfg_chan;
          p_div  = (cfg_div == 0) ? 1 : cfg_div;
`ifdef CLKDIV_PHASE_EN
          p_phase = cfg_phase;
`else
          p_phase = 0;
`endif
        end
        m_ready  = !m_pend && (m_t >= m_lock_at);
        e.locked = m_ready;
        e.ready  = m_ready;
        exp_q.push_back(e);
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: DUT outputs present but no expectation queued");
      end else begin
        e = exp_q.pop_front();
        if ({tick, clk_out, locked, cfg_ready} !== e) begin
          errors++;
          $display("FAIL outputs t=%0d: got tick=%b clk_out=%b locked=%b ready=%b, expected tick=%b clk_out=%b locked=%b ready=%b",
                   m_t, tick, clk_out, locked, cfg_ready, e.tick, e.clk_out, e.locked, e.ready);
        end
      end
    end
  end

  // Caller must be at a falling edge; payload is held until the DUT shows ready at an edge.
  task automatic send(input int unsigned ch, input int unsigned dv, input int unsigned ph);
    int unsigned waited = 0;
    #1;
    cfg_valid = 1'b1;
    cfg_chan  = CH_W'(ch);
    cfg_div   = DIV_W'(dv);
`ifdef CLKDIV_PHASE_EN
    cfg_phase = DIV_W'(ph);
`else
    if (ph > 0) waited = 0;
`endif
    while (cfg_ready !== 1'b1 && waited < 400) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout: cfg_ready=%b after %0d cycles, required 1", cfg_ready, waited);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_t(input int unsigned n);
    int unsigned k = 0;
    while (m_t < n && k < 5000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (m_t < n) begin
      errors++;
      $display("FAIL wait_t_timeout: reached t=%0d, required %0d", m_t, n);
    end
  endtask

  // Lands at a falling edge inside a channel-0 wrap cycle while the block is ready.
  task automatic wait_wrap0();
    int unsigned k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(m_ready && cnt_at(0, m_t) == m_dv[0] - 1) && k < 1000);
    checks++;
    if (k >= 1000) begin
      errors++;
      $display("FAIL wrap_wait_timeout: no ready wrap cycle on ch0 within %0d cycles", k);
    end
  endtask

  initial begin : driver
    int unsigned ch, dv, ph, d;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;

    // Defaults, then ch1 -> 10 accepted while ch1 is at count 50.
    wait_t(170);
    send(1, 10, 0);
    repeat (2) @(negedge clk);
    send(3, 5, 0);

    // Reset while a request for ch2 is pending.
    @(negedge clk);
    send(2, 4, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    checks++;
    if ({tick, clk_out, locked, cfg_ready} !== '0) begin
      errors++;
      $display("FAIL reset_async: got tick=%b clk_out=%b locked=%b ready=%b, required all 0",
               tick, clk_out, locked, cfg_ready);
    end
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    wait_t(140);

    @(negedge clk);
    send(2, 0, 0);
    repeat (20) @(negedge clk);
    send(1, 7, 0);
    repeat (20) @(negedge clk);
    send(0, 9, 0);

    wait_wrap0();
    send(0, 1, 0);
    repeat (5) @(negedge clk);
    send(0, 8, 20);

    for (int n = 0; n < 14; n++) begin
      ch = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0:       dv = 0;
        1:       dv = 1;
        2:       dv = 7;
        default: dv = $urandom_range(2, 40);
      endcase
      ph = $urandom_range(0, 50);
      d  = $urandom_range(1, 20);
      repeat (d) @(negedge clk);
      send(ch, dv, ph);
    end

    repeat (150) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

endmodule
